// File: rtl/edge_timestamper_if.sv
// Output stream of the edge timestamper: show-ahead FIFO head word with a valid/ready handshake.
interface edge_timestamper_if #(
    parameter int unsigned CNT_W = 14
);
    logic [CNT_W+1:0] oData;
    logic             oValid;
    logic             iReady;

    modport master (output oData, output oValid, input iReady);
    modport slave  (input oData, input oValid, output iReady);
endinterface

// File: rtl/edge_timestamper.sv
// Timestamps rise/fall pulses against a free-running coarse counter, inserts rollover markers,
// and queues the words in a show-ahead FIFO with drop accounting.
module edge_timestamper #(
    parameter int unsigned CNT_W = 14,
    parameter int unsigned DEPTH = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               enable,
    input  logic               iRise,
    input  logic               iFall,
    edge_timestamper_if.master outBus,
    output logic               oOverflow,
    output logic [7:0]         oDropCnt
);
    localparam int unsigned WORD_W = CNT_W + 2;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;

    logic [CNT_W-1:0]  coarse;
    logic              stMarker;
    logic              stHit;
    logic [1:0]        stType;
    logic [CNT_W-1:0]  stTs;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [OCC_W-1:0]  occ;

    logic              pop;
    logic [OCC_W-1:0]  occAfterPop;
    logic [OCC_W-1:0]  freeSlots;
    logic [OCC_W-1:0]  occNext;
    logic [1:0]        nReq;
    logic [1:0]        nWr;
    logic [1:0]        nDrop;
    logic [PTR_W-1:0]  wrPtrB;
    logic [PTR_W-1:0]  rdNext;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    logic [WORD_W-1:0] headNext;
    logic [WORD_W-1:0] dataNext;
    logic [8:0]        dropSum;
    logic [7:0]        dropSat;

    // Coarse counter: runs only while enabled, wraps naturally.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            coarse <= '0;
        end else if (enable) begin
            coarse <= coarse + CNT_W'(1);
        end
    end

    // Capture stage: the pre-increment count, so marker and hit from one cycle share a timestamp.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            stMarker <= 1'b0;
            stHit    <= 1'b0;
            stType   <= 2'b00;
            stTs     <= '0;
        end else begin
            stMarker <= enable && (&coarse);
            stHit    <= enable && (iRise || iFall);
            stType   <= {iFall, iRise};
            stTs     <= coarse;
        end
    end

    // Write stage: admit words against occupancy after this cycle's pop, marker first.
    always_comb begin
        pop         = outBus.oValid && outBus.iReady;
        occAfterPop = occ - OCC_W'(pop);
        freeSlots   = OCC_W'(DEPTH) - occAfterPop;
        nReq        = 2'(stMarker) + 2'(stHit);
        nWr         = (freeSlots >= OCC_W'(nReq)) ? nReq : 2'(freeSlots);
        nDrop       = nReq - nWr;
        word0       = stMarker ? {2'b00, {CNT_W{1'b1}}} : {stType, stTs};
        word1       = {stType, stTs};
        wrPtrB      = wrPtr + PTR_W'(1);
        rdNext      = rdPtr + PTR_W'(pop);
        occNext     = occAfterPop + OCC_W'(nWr);

        headNext = mem[rdNext];
        if (nWr != 2'd0 && wrPtr == rdNext) begin
            headNext = word0;
        end else if (nWr == 2'd2 && wrPtrB == rdNext) begin
            headNext = word1;
        end
        dataNext = (occNext == '0) ? outBus.oData : headNext;

        dropSum = {1'b0, oDropCnt} + 9'(nDrop);
        dropSat = (dropSum > 9'd255) ? 8'hFF : dropSum[7:0];
    end

    always_ff @(posedge iClk) begin
        if (nWr != 2'd0) begin
            mem[wrPtr] <= word0;
        end
        if (nWr == 2'd2) begin
            mem[wrPtrB] <= word1;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            occ           <= '0;
            outBus.oValid <= 1'b0;
            outBus.oData  <= '0;
            oOverflow     <= 1'b0;
            oDropCnt      <= '0;
        end else begin
            wrPtr         <= wrPtr + PTR_W'(nWr);
            rdPtr         <= rdNext;
            occ           <= occNext;
            outBus.oValid <= (occNext != '0);
            outBus.oData  <= dataNext;
            if (nDrop != 2'd0) begin
                oOverflow <= 1'b1;
                oDropCnt  <= dropSat;
            end
        end
    end
endmodule

// File: tb/tb_edge_timestamper.sv
// Directed bench for edge_timestamper with a queue scoreboard mirroring the expected FIFO contents.
module tb_edge_timestamper;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned WORD_W = CNT_W + 2;

    logic       iClk   = 1'b0;
    logic       iRst   = 1'b0;
    logic       enable = 1'b0;
    logic       iRise  = 1'b0;
    logic       iFall  = 1'b0;
    logic       oOverflow;
    logic [7:0] oDropCnt;

    edge_timestamper_if #(.CNT_W(CNT_W)) bus();

    edge_timestamper #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .enable    (enable),
        .iRise     (iRise),
        .iFall     (iFall),
        .outBus    (bus),
        .oOverflow (oOverflow),
        .oDropCnt  (oDropCnt)
    );

    always #5 iClk = ~iClk;

    int nAssert = 0;
    int nFail   = 0;

    logic [WORD_W-1:0] sbq  [$];
    logic [WORD_W-1:0] pend [$];
    logic [CNT_W-1:0]  mCnt;
    logic              mOvf;
    logic [7:0]        mDrop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        sbq.delete();
        pend.delete();
        mCnt  = '0;
        mOvf  = 1'b0;
        mDrop = '0;
    endtask

    // Behaviour at the coming rising edge, from the inputs the bench is driving now.
    task automatic modelEdge();
        if (!iRst) return;
        if (sbq.size() != 0 && bus.iReady) void'(sbq.pop_front());
        foreach (pend[i]) begin
            if (sbq.size() < DEPTH) begin
                sbq.push_back(pend[i]);
            end else begin
                mOvf = 1'b1;
                if (mDrop != 8'hFF) mDrop++;
            end
        end
        pend.delete();
        if (enable) begin
            if (mCnt == 4'hF) pend.push_back({2'b00, 4'hF});
            if (iRise || iFall) pend.push_back({iFall, iRise, mCnt});
            mCnt++;
        end
    endtask

    task automatic checkOutputs();
        check("oValid", 32'(bus.oValid), 32'(sbq.size() != 0));
        if (sbq.size() != 0) check("oData", 32'(bus.oData), 32'(sbq[0]));
        check("oOverflow", 32'(oOverflow), 32'(mOvf));
        check("oDropCnt", 32'(oDropCnt), 32'(mDrop));
    endtask

    task automatic tick();
        modelEdge();
        @(posedge iClk);
        #1;
        checkOutputs();
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_valid"}, 32'(bus.oValid), 32'd0);
        check({tag, "_data"}, 32'(bus.oData), 32'd0);
        check({tag, "_ovf"}, 32'(oOverflow), 32'd0);
        check({tag, "_drops"}, 32'(oDropCnt), 32'd0);
    endtask

    // Assert reset between edges, check the immediate clear, hold across one edge, release.
    task automatic doReset(input string tag);
        #3;
        iRst = 1'b0;
        modelClear();
        #1;
        checkZero(tag);
        tick();
        iRst = 1'b1;
    endtask

    initial begin
        bus.iReady = 1'b0;
        modelClear();

        // Power-on reset
        #12;
        checkZero("por");
        @(posedge iClk);
        #1;
        iRst       = 1'b1;
        enable     = 1'b1;
        bus.iReady = 1'b1;

        // Single hit at counter 5
        repeat (5) tick();
        iRise = 1'b1;
        tick();
        iRise = 1'b0;
        tick();
        check("single_valid", 32'(bus.oValid), 32'd1);
        check("single_data", 32'(bus.oData), 32'h15);
        tick();
        check("single_gone", 32'(bus.oValid), 32'd0);

        // Rollover collision: marker ordered before the fall word, both at 15
        while (mCnt != 4'hF) tick();
        bus.iReady = 1'b0;
        iFall      = 1'b1;
        tick();
        iFall = 1'b0;
        tick();
        check("roll_marker", 32'(bus.oData), 32'h0F);
        bus.iReady = 1'b1;
        tick();
        check("roll_fall", 32'(bus.oData), 32'h2F);
        tick();
        iRise = 1'b1;
        tick();
        iRise = 1'b0;
        repeat (3) tick();

        // Backpressure: nine hits into eight slots
        doReset("rst_a");
        bus.iReady = 1'b0;
        iRise      = 1'b1;
        repeat (9) tick();
        iRise = 1'b0;
        tick();
        check("bp_ovf", 32'(oOverflow), 32'd1);
        check("bp_drops", 32'(oDropCnt), 32'd1);
        check("bp_head", 32'(bus.oData), 32'h10);

        // Full FIFO: pop and push in the same cycle drops nothing
        iRise = 1'b1;
        tick();
        iRise      = 1'b0;
        bus.iReady = 1'b1;
        tick();
        check("full_pop_drops", 32'(oDropCnt), 32'd1);
        check("full_pop_head", 32'(bus.oData), 32'h11);
        bus.iReady = 1'b0;
        enable     = 1'b0;
        tick();
        bus.iReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(bus.oValid), 32'd1);
            tick();
        end
        check("drain_empty", 32'(bus.oValid), 32'd0);

        // Disabled pulses ignored, counter frozen; then a conflict word
        iRise = 1'b1;
        iFall = 1'b1;
        tick();
        iRise = 1'b0;
        iFall = 1'b0;
        tick();
        check("disabled_valid", 32'(bus.oValid), 32'd0);
        enable = 1'b1;
        iRise  = 1'b1;
        iFall  = 1'b1;
        tick();
        iRise = 1'b0;
        iFall = 1'b0;
        tick();
        check("conflict_valid", 32'(bus.oValid), 32'd1);
        check("conflict_data", 32'(bus.oData), 32'h3C);
        tick();

        // Reset mid-burst, pulses held through reset and into the first cycle after
        bus.iReady = 1'b0;
        iRise      = 1'b1;
        repeat (4) tick();
        check("burst_ovf_set", 32'(oOverflow), 32'd1);
        doReset("rst_b");
        tick();
        iRise = 1'b0;
        tick();
        check("post_rst_data", 32'(bus.oData), 32'h10);
        check("post_rst_ovf", 32'(oOverflow), 32'd0);
        check("post_rst_drops", 32'(oDropCnt), 32'd0);
        bus.iReady = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/edge_timestamper.md
EDGE_TIMESTAMPER -- requirements
Module: edge_timestamper

Interface
REQ-001 Parameter CNT_W, default 14: coarse counter width in bits.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, minimum 4.
REQ-003 iClk  input  1  single clock; all state updates on its rising edge.
REQ-004 iRst  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to iClk externally.
REQ-005 enable  input  1  when high, the counter runs and hits are accepted; when low, the counter holds and hits are ignored.
REQ-006 iRise  input  1  one-cycle rising-edge pulse from the edge detector stage.
REQ-007 iFall  input  1  one-cycle falling-edge pulse from the edge detector stage.
REQ-008 oData  output  CNT_W+2  FIFO head word: [CNT_W+1:CNT_W] type, [CNT_W-1:0] coarse timestamp.
REQ-009 oValid  output  1  oData holds a valid head word.
REQ-010 iReady  input  1  the consumer accepts the head word in any cycle where oValid and iReady are both high.
REQ-011 oOverflow  output  1  sticky flag: at least one word was dropped.
REQ-012 oDropCnt  output  8  count of dropped words, saturating at 255.

Function
REQ-013 Type codes: 00 rollover marker, 01 rise, 10 fall, 11 conflict (iRise and iFall both high in one cycle).
REQ-014 The coarse counter shall increment by 1 each cycle while enable is high and shall wrap from 2^CNT_W-1 to 0.
REQ-015 Hit timestamp shall be the counter value in the same cycle as the pulse, before that cycle's increment.
REQ-016 The rollover marker shall be generated in any enabled cycle where the counter equals 2^CNT_W-1, with timestamp field all ones.
REQ-017 A hit in an enabled cycle shall produce exactly one word: 01, 10, or 11 (if both pulses are high, one 11 word).
REQ-018 Per cycle there shall be up to two writes; the marker is ordered before a hit from the same cycle.
REQ-019 Write latency: a pulse at edge N shall make the word visible in the FIFO after edge N+1; oValid shall rise after edge N+1 if the FIFO was empty.
REQ-020 FIFO is show-ahead: oData always reflects the head entry; pop on oValid & iReady.
REQ-021 oData shall be stable while oValid is high and iReady is low.
REQ-022 Free-space check shall use occupancy after the same-cycle pop.
- If two writes are requested and only one slot is free, the marker is written and the hit is dropped.
- If no slot is free, all requested words are dropped.
REQ-023 Each dropped word shall set oOverflow and increment oDropCnt by 1, or by 2 when two words drop in one cycle, saturating at 255.
REQ-024 Simultaneous pop and push on a full FIFO shall succeed without drop.
REQ-025 With enable low, no words are written and the counter holds; the output side keeps draining.
REQ-026 Occupancy shall never exceed DEPTH; read and write pointers shall wrap modulo DEPTH.

Reset
REQ-027 While iRst is low, the following shall be cleared asynchronously: counter 0, FIFO empty, oValid 0, oData 0, oOverflow 0, oDropCnt 0.
REQ-028 Pulses present during reset, or in the first cycle after deassertion, shall be treated normally only from the first enabled edge after deassertion.
REQ-029 Reset asserted mid-operation shall discard all FIFO contents with no partial words emitted.
REQ-030 oOverflow and oDropCnt shall be cleared only by reset.

Verification
REQ-031 Single hit: enable=1, counter=5, iRise pulse, iReady=1 -> next cycle oValid=1, oData={01,5}; oValid=0 the cycle after.
REQ-032 Rollover collision: CNT_W=4, iFall at counter 15 -> two words in order {00,15}, {10,15}; the next hit carries a timestamp of 0 or more.
REQ-033 Backpressure: iReady=0, 9 rise pulses into DEPTH=8 -> 8 words stored, oOverflow=1, oDropCnt=1, oData stable.
REQ-034 Full with pop: FIFO full, iReady=1, hit in the same cycle -> no drop, occupancy stays 8.
REQ-035 Conflict and enable: iRise=iFall=1 -> one {11,t} word; with enable=0, pulses are ignored and the counter is frozen.
REQ-036 Async reset: assert iRst=0 mid-burst between clock edges -> all outputs 0 immediately; after release, the first hit has the counter value from 0.
